// File: rtl/multichunk_add_seq.sv
// Chunk-serial adder/subtractor: streams a WIDTH-bit add through a CHUNK-bit
// carry-select slice, one slice per clock, with valid/ready on both sides.

module cs_add_slice #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         ci,
  output logic [W-1:0] s,
  output logic         co
);
  localparam int LO = W / 2;
  localparam int HI = W - LO;

  logic [LO:0] lo_sum;
  logic [HI:0] hi_c0, hi_c1;

  // Upper half is precomputed for both carries and picked by the lower carry.
  assign lo_sum = {1'b0, a[LO-1:0]} + {1'b0, b[LO-1:0]} + {{LO{1'b0}}, ci};
  assign hi_c0  = {1'b0, a[W-1:LO]} + {1'b0, b[W-1:LO]};
  assign hi_c1  = {1'b0, a[W-1:LO]} + {1'b0, b[W-1:LO]} + {{HI{1'b0}}, 1'b1};

  assign {co, s} = lo_sum[LO] ? {hi_c1, lo_sum[LO-1:0]} : {hi_c0, lo_sum[LO-1:0]};
endmodule

module multichunk_add_seq #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             busy
);
  localparam int NCH  = WIDTH / CHUNK;
  localparam int IDXW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [IDXW-1:0] LAST = IDXW'(NCH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                      state_q, state_d;
  logic [IDXW-1:0]             idx_q, idx_d;
  logic [NCH-1:0][CHUNK-1:0]   a_q, a_d;
  logic [NCH-1:0][CHUNK-1:0]   b_q, b_d;
  logic [NCH-1:0][CHUNK-1:0]   sum_q, sum_d;
  logic                        carry_q, carry_d;
  logic                        cout_q, cout_d;
  logic                        ovf_q, ovf_d;

  logic [CHUNK-1:0]            sl_s;
  logic                        sl_co;

  cs_add_slice #(.W(CHUNK)) u_slice (
    .a  (a_q[idx_q]),
    .b  (b_q[idx_q]),
    .ci (carry_q),
    .s  (sl_s),
    .co (sl_co)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          // b_q holds the effective operand so the slice only ever adds.
          a_d     = a;
          b_d     = sub ? ~b : b;
          carry_d = sub ? 1'b1 : cin;
          idx_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        sum_d[idx_q] = sl_s;
        carry_d      = sl_co;
        idx_d        = idx_q + 1'b1;
        if (idx_q == LAST) begin
          cout_d  = sl_co;
          ovf_d   = (a_q[NCH-1][CHUNK-1] == b_q[NCH-1][CHUNK-1]) &&
                    (sl_s[CHUNK-1] != a_q[NCH-1][CHUNK-1]);
          idx_d   = '0;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  // All handshake outputs are pure state decodes: no input-to-output paths.
  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;
endmodule

// File: tb/tb_multichunk_add_seq.sv
// Randomized scoreboard bench for multichunk_add_seq (WIDTH=32, CHUNK=8).

module tb_multichunk_add_seq;
  localparam int W   = 32;
  localparam int NCH = 4;

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } res_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic         sub = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;
  logic         busy;

  int   checks = 0;
  int   errors = 0;
  res_t exp_q[$];

  multichunk_add_seq #(.WIDTH(W), .CHUNK(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf), .busy(busy)
  );

  always #5 clk = ~clk;

  // Reference: true integer arithmetic, signed range check for overflow.
  function automatic res_t model(logic [W-1:0] x, logic [W-1:0] y, logic ci, logic sb);
    res_t   m;
    longint ux, uy, sx, sy, r, sr;
    ux = x; uy = y;
    sx = $signed(x); sy = $signed(y);
    if (sb) begin
      r = ux - uy; sr = sx - sy; m.cout = (ux >= uy);
    end else begin
      r = ux + uy + ci; sr = sx + sy + ci; m.cout = (r >= 64'h1_0000_0000);
    end
    m.sum = r[W-1:0];
    m.ovf = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
    return m;
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic timeout(string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out waiting for DUT", name);
  endtask

  // Monitor: a result is consumed at the next edge whenever valid & ready.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        timeout("unexpected_output");
      end else begin
        res_t e;
        e = exp_q.pop_front();
        chk("sum", 64'(sum), 64'(e.sum));
        chk("cout", 64'(cout), 64'(e.cout));
        chk("ovf", 64'(ovf), 64'(e.ovf));
        chk("in_ready_in_done", 64'(in_ready), 64'd0);
      end
    end
  end

  // Called at #1 after the accept edge; out_valid must rise exactly NCH edges later.
  task automatic wait_out(int lat_req);
    int n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (!out_valid) timeout("wait_out_valid");
    else chk("latency", 64'(n), 64'(lat_req));
  endtask

  task automatic issue(logic [W-1:0] x, logic [W-1:0] y, logic ci, logic sb);
    int n = 0;
    while (!in_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) timeout("wait_in_ready");
    a = x; b = y; cin = ci; sub = sb; in_valid = 1'b1;
    exp_q.push_back(model(x, y, ci, sb));
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = $urandom; b = $urandom;
    chk("busy_after_accept", 64'(busy), 64'd1);
    wait_out(NCH);
  endtask

  task automatic drain(int hold);
    repeat (hold) begin
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  function automatic logic [W-1:0] rnd32();
    case ($urandom_range(0, 7))
      0: return 32'hFFFF_FFFF;
      1: return 32'h7FFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h0000_0001;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    res_t e1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_sum", 64'(sum), 64'd0);
    chk("rst_cout", 64'(cout), 64'd0);
    chk("rst_ovf", 64'(ovf), 64'd0);

    // Directed vectors from the plan.
    issue(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0); drain(0);
    issue(32'h00FF_00FF, 32'h0001_0001, 1'b1, 1'b0); drain(1);
    issue(32'd5, 32'd7, 1'b1, 1'b1);                 drain(0);
    issue(32'd7, 32'd5, 1'b0, 1'b1);                 drain(2);
    issue(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0); drain(0);
    issue(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1); drain(0);

    // Backpressure with in_valid held high through DONE.
    issue(32'h1234_5678, 32'h0F0F_0F0F, 1'b0, 1'b0);
    e1 = model(32'h1234_5678, 32'h0F0F_0F0F, 1'b0, 1'b0);
    a = 32'hDEAD_BEEF; b = 32'h0000_1111; cin = 1'b1; sub = 1'b0; in_valid = 1'b1;
    repeat (5) begin
      @(posedge clk); #1;
      chk("bp_in_ready", 64'(in_ready), 64'd0);
      chk("bp_out_valid", 64'(out_valid), 64'd1);
      chk("bp_sum", 64'(sum), 64'(e1.sum));
      chk("bp_cout", 64'(cout), 64'(e1.cout));
      chk("bp_ovf", 64'(ovf), 64'(e1.ovf));
    end
    exp_q.push_back(model(32'hDEAD_BEEF, 32'h0000_1111, 1'b1, 1'b0));
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("bp_idle_in_ready", 64'(in_ready), 64'd1);
    chk("bp_idle_out_valid", 64'(out_valid), 64'd0);
    chk("bp_idle_busy", 64'(busy), 64'd0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("bp_accept_busy", 64'(busy), 64'd1);
    wait_out(NCH);
    drain(0);

    // Reset after the second chunk edge aborts without a result.
    a = 32'hAAAA_AAAA; b = 32'h5555_5555; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_in_ready", 64'(in_ready), 64'd1);
    chk("abort_out_valid", 64'(out_valid), 64'd0);
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_sum", 64'(sum), 64'd0);
    repeat (8) @(posedge clk);
    #1 chk("abort_no_result", 64'(out_valid), 64'd0);

    // Randomized traffic with random consumer stalls.
    for (int i = 0; i < 60; i++) begin
      issue(rnd32(), rnd32(), 1'($urandom), 1'($urandom));
      drain($urandom_range(0, 3));
    end

    repeat (3) @(posedge clk);
    #1 chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
